// File: rtl/amba_ahb_arbiter.sv
// AHB bus arbiter: round-robin one-hot grant with burst/INCR hold; new grant visible one cycle after the arbitration edge.
// hready=0 freezes hmaster and arbitration; locked transfers only when AHB_ARB_LOCK_EN is defined.
module amba_ahb_arbiter #(
  parameter int NM    = 4,
  parameter int DEF_M = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [NM-1:0]         hbusreq,
  input  logic [NM-1:0]         hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  output logic [NM-1:0]         hgrant,
  output logic [$clog2(NM)-1:0] hmaster,
  output logic                  hmastlock
);
  localparam int            MW      = $clog2(NM);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEF_M);
  localparam logic [NM-1:0] DEF_GNT = NM'(1) << DEF_M;

  localparam logic [1:0] TR_BUSY    = 2'b01;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] BURST_INCR = 3'b001;

  logic [NM-1:0] grant_q, grant_d;
  logic [MW-1:0] hmaster_q, hmaster_d;
  logic          hmastlock_q, hmastlock_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [MW-1:0] last_q, last_d;
  logic          lock_hold_q, lock_hold_d;

  logic [MW-1:0] gidx;
  logic [MW-1:0] win;
  logic [MW-1:0] ri;
  logic          found;
  logic [3:0]    blen;
  logic          incr_hold;
  logic          burst_start;
  logic          arb_pt;

  always_comb begin
    gidx = DEF_IDX;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) gidx = MW'(i);
    end

    case (hburst)
      3'b010, 3'b011: blen = 4'd3;
      3'b100, 3'b101: blen = 4'd7;
      3'b110, 3'b111: blen = 4'd15;
      default:        blen = 4'd0;
    endcase

    // An INCR burst keeps the bus while its owner still requests; a starting burst never re-arbitrates.
    incr_hold   = (hburst == BURST_INCR) && hbusreq[hmaster_q] &&
                  ((htrans == TR_SEQ) || (htrans == TR_BUSY));
    burst_start = hready && (htrans == TR_NONSEQ) &&
                  ((blen != 4'd0) || ((hburst == BURST_INCR) && hbusreq[hmaster_q]));
    arb_pt      = hready && (cnt_q == 4'd0) && !lock_hold_q && !incr_hold && !burst_start;

    found = 1'b0;
    win   = DEF_IDX;
    ri    = DEF_IDX;
    for (int i = 1; i <= NM; i++) begin
      ri = MW'((int'(last_q) + i) % NM);
      if (!found && hbusreq[ri]) begin
        found = 1'b1;
        win   = ri;
      end
    end

    grant_d = grant_q;
    last_d  = last_q;
    if (arb_pt) begin
      grant_d = NM'(1) << win;
      if (found) last_d = win;
    end

    hmaster_d = hready ? gidx : hmaster_q;

    cnt_d = cnt_q;
    if ((hresp == RESP_ERROR) && !hready) begin
      cnt_d = 4'd0;
    end else if (hready && (htrans == TR_NONSEQ)) begin
      cnt_d = blen;
    end else if (hready && (htrans == TR_SEQ) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  // Hold drops on the first accepted transfer that sees the owner's hlock low.
  always_comb begin
    lock_hold_d = lock_hold_q;
    if (arb_pt) begin
      lock_hold_d = hlock[win];
    end else if (lock_hold_q && hready && !hlock[gidx]) begin
      lock_hold_d = 1'b0;
    end
    hmastlock_d = hready ? hlock[gidx] : hmastlock_q;
  end
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign lock_hold_d  = 1'b0;
  assign hmastlock_d  = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      grant_q     <= DEF_GNT;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      cnt_q       <= 4'd0;
      last_q      <= DEF_IDX;
      lock_hold_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      lock_hold_q <= lock_hold_d;
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_amba_ahb_arbiter.sv
// Directed-vector bench for amba_ahb_arbiter; stimulus queues hand-computed expectations, a monitor checks them.
module tb_amba_ahb_arbiter;
  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011;
  localparam logic [2:0] B_INCR8 = 3'b101, B_WRAP16 = 3'b110;
  localparam logic [1:0] OK = 2'b00, ERR = 2'b01;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   step_n    = 0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  amba_ahb_arbiter #(.NM(4), .DEF_M(0)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string nm, input int st, input logic [3:0] got, input logic [3:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", nm, st, got, want);
  endtask

  // One clock: drive inputs at negedge, queue the state expected after the next rising edge.
  task automatic cyc(input logic rst_n, input logic [3:0] req, input logic [3:0] lk,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                     input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                     input logic el);
    @(negedge hclk);
    hresetn = rst_n;
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    step_n++;
    exp_q.push_back('{g: eg, m: em, l: el, step: step_n});
    @(posedge hclk);
  endtask

  task automatic c(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                   input logic rdy, input logic [1:0] rsp, input logic [3:0] eg,
                   input logic [1:0] em);
    cyc(1'b1, req, 4'b0000, tr, bu, rdy, rsp, eg, em, 1'b0);
  endtask

  task automatic rst();
    repeat (2) cyc(1'b0, 4'b0000, 4'b0000, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge hclk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hgrant", e.step, hgrant, e.g);
        chk("hmaster", e.step, {2'b00, hmaster}, {2'b00, e.m});
        chk("hmastlock", e.step, {3'b000, hmastlock}, {3'b000, e.l});
        chk("onehot", e.step, {3'b000, $onehot(hgrant)}, 4'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = TI;
    hburst  = B_SINGLE;
    hready  = 1'b1;
    hresp   = OK;

    // Reset state and idle default grant
    rst();
    c(4'b0000, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd0);

    // Round robin over single transfers
    rst();
    c(4'b1111, TN, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0);
    c(4'b1111, TN, B_SINGLE, 1'b1, OK, 4'b0100, 2'd1);
    c(4'b1111, TN, B_SINGLE, 1'b1, OK, 4'b1000, 2'd2);
    c(4'b1111, TN, B_SINGLE, 1'b1, OK, 4'b0001, 2'd3);
    c(4'b1111, TN, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0);

    // Master 1 INCR4 holds the grant for four beats
    rst();
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0);
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0101, TN, B_INCR4, 1'b1, OK, 4'b0010, 2'd1);
    repeat (3) c(4'b0101, TS, B_INCR4, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0101, TI, B_SINGLE, 1'b1, OK, 4'b0100, 2'd1);
    c(4'b0101, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd2);

    // Master 2 INCR8 with a two-cycle wait state mid-burst
    rst();
    c(4'b0100, TI, B_SINGLE, 1'b1, OK, 4'b0100, 2'd0);
    c(4'b0100, TI, B_SINGLE, 1'b1, OK, 4'b0100, 2'd2);
    c(4'b0001, TN, B_INCR8, 1'b1, OK, 4'b0100, 2'd2);
    repeat (3) c(4'b0001, TS, B_INCR8, 1'b1, OK, 4'b0100, 2'd2);
    repeat (2) c(4'b0001, TS, B_INCR8, 1'b0, OK, 4'b0100, 2'd2);
    repeat (4) c(4'b0001, TS, B_INCR8, 1'b1, OK, 4'b0100, 2'd2);
    c(4'b0001, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd2);
    c(4'b0001, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd0);

    // Master 3 WRAP16 aborted by ERROR after beat 5
    rst();
    c(4'b1000, TI, B_SINGLE, 1'b1, OK, 4'b1000, 2'd0);
    c(4'b1000, TI, B_SINGLE, 1'b1, OK, 4'b1000, 2'd3);
    c(4'b1001, TN, B_WRAP16, 1'b1, OK, 4'b1000, 2'd3);
    repeat (4) c(4'b1001, TS, B_WRAP16, 1'b1, OK, 4'b1000, 2'd3);
    c(4'b1001, TS, B_WRAP16, 1'b0, ERR, 4'b1000, 2'd3);
    c(4'b1001, TI, B_WRAP16, 1'b1, ERR, 4'b0001, 2'd3);
    c(4'b1001, TI, B_SINGLE, 1'b1, OK, 4'b1000, 2'd0);

    // Undefined-length INCR held while master 1 keeps requesting
    rst();
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0);
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0011, TN, B_INCR, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0011, TS, B_INCR, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0011, TB, B_INCR, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0001, TS, B_INCR, 1'b1, OK, 4'b0001, 2'd1);
    c(4'b0000, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd0);

    // Default grant leaves the round-robin pointer alone
    rst();
    c(4'b0100, TI, B_SINGLE, 1'b1, OK, 4'b0100, 2'd0);
    c(4'b0000, TI, B_SINGLE, 1'b1, OK, 4'b0001, 2'd2);
    c(4'b1011, TI, B_SINGLE, 1'b1, OK, 4'b1000, 2'd0);

    // Reset in the middle of a burst drops it entirely
    rst();
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0);
    c(4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0010, TN, B_INCR4, 1'b1, OK, 4'b0010, 2'd1);
    c(4'b0010, TS, B_INCR4, 1'b1, OK, 4'b0010, 2'd1);
    rst();
    c(4'b0100, TI, B_SINGLE, 1'b1, OK, 4'b0100, 2'd0);

    // Master 1 asserts hlock for three transfers
    rst();
    cyc(1'b1, 4'b1111, 4'b0010, TI, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0, 1'b0);
`ifdef AHB_ARB_LOCK_EN
    repeat (3) cyc(1'b1, 4'b1111, 4'b0010, TN, B_SINGLE, 1'b1, OK, 4'b0010, 2'd1, 1'b1);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b0100, 2'd1, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b1000, 2'd2, 1'b0);
`else
    cyc(1'b1, 4'b1111, 4'b0010, TN, B_SINGLE, 1'b1, OK, 4'b0100, 2'd1, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0010, TN, B_SINGLE, 1'b1, OK, 4'b1000, 2'd2, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0010, TN, B_SINGLE, 1'b1, OK, 4'b0001, 2'd3, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b0010, 2'd0, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b0100, 2'd1, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, TN, B_SINGLE, 1'b1, OK, 4'b1000, 2'd2, 1'b0);
`endif

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge hclk);
    #2;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
